alu_op_issue: RTL

//  Drives the 64-bit ALU's operand/opcode interface from decoded instructions, and captures its Result/ZERO.
//  Two-stage valid/ready pipeline: E registers operands and the 4-bit ALU opcode; W captures the ALU result and branch decision.

---
 rtl/alu_pkg.sv | 50 +++++
 rtl/alu_op_decode.sv | 85 ++++++++
 rtl/alu_op_issue.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// Package     : alu_pkg
// Description : Shared encodings for the ALU issue stage: ALU opcodes, the
//               decoder's aluop classes, branch funct3 codes and branch kinds.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    // ALU Op encodings understood by the downstream combinational ALU
    localparam logic [3:0] ALU_OP_AND     = 4'b0000;
    localparam logic [3:0] ALU_OP_OR      = 4'b0001;
    localparam logic [3:0] ALU_OP_ADD     = 4'b0010;
    localparam logic [3:0] ALU_OP_SUB     = 4'b0110;
    localparam logic [3:0] ALU_OP_BLT     = 4'b1000;
    localparam logic [3:0] ALU_OP_NOR     = 4'b1100;
    localparam logic [3:0] ALU_OP_ILLEGAL = 4'b1111;

    // Instruction class supplied by the main decoder
    localparam logic [1:0] ALUOP_MEM     = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH  = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE   = 2'b10;
    localparam logic [1:0] ALUOP_ILLEGAL = 2'b11;

    // Branch funct3 codes
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;

    // R-type funct3 codes
    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_XOR    = 3'b100;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;

    typedef enum logic [1:0] {
        BR_EQ = 2'd0,
        BR_NE = 2'd1,
        BR_LT = 2'd2
    } br_kind_e;

    // ZERO means "equal" for beq/bne and "less than" for blt, so only bne inverts it
    function automatic logic branch_taken(input logic [1:0] kind, input logic zero);
        branch_taken = (kind == BR_NE) ? !zero : zero;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_op_decode.sv
// ============================================================================
// Module      : alu_op_decode
// Description : Combinational map (aluop, funct3, funct7b5) -> ALU Op plus
//               branch kind and illegal flag.
//               Macro ALU_ISSUE_NOR_EN: R-type funct3=100 with funct7b5=1
//               decodes to NOR instead of illegal.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_decode
    import alu_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output logic [3:0] op_o,
    output logic       is_branch_o,
    output logic [1:0] br_kind_o,
    output logic       illegal_o
);

    // Opcode table; every unsupported combination issues the illegal op
    always_comb begin
        op_o        = ALU_OP_ADD;
        is_branch_o = 1'b0;
        br_kind_o   = BR_EQ;
        illegal_o   = 1'b0;
        case (aluop_i)
            ALUOP_MEM: begin
                op_o = ALU_OP_ADD;
            end
            ALUOP_BRANCH: begin
                is_branch_o = 1'b1;
                case (funct3_i)
                    F3_BEQ: begin
                        op_o      = ALU_OP_SUB;
                        br_kind_o = BR_EQ;
                    end
                    F3_BNE: begin
                        op_o      = ALU_OP_SUB;
                        br_kind_o = BR_NE;
                    end
                    F3_BLT: begin
                        op_o      = ALU_OP_BLT;
                        br_kind_o = BR_LT;
                    end
                    default: begin
                        op_o        = ALU_OP_ILLEGAL;
                        is_branch_o = 1'b0;
                        illegal_o   = 1'b1;
                    end
                endcase
            end
            ALUOP_RTYPE: begin
                case (funct3_i)
                    F3_ADDSUB: op_o = funct7b5_i ? ALU_OP_SUB : ALU_OP_ADD;
                    F3_AND:    op_o = ALU_OP_AND;
                    F3_OR:     op_o = ALU_OP_OR;
`ifdef ALU_ISSUE_NOR_EN
                    F3_XOR: begin
                        if (funct7b5_i) begin
                            op_o = ALU_OP_NOR;
                        end else begin
                            op_o      = ALU_OP_ILLEGAL;
                            illegal_o = 1'b1;
                        end
                    end
`endif
                    default: begin
                        op_o      = ALU_OP_ILLEGAL;
                        illegal_o = 1'b1;
                    end
                endcase
            end
            default: begin
                op_o      = ALU_OP_ILLEGAL;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_op_issue.sv
// ============================================================================
// Module      : alu_op_issue
// Description : Two-stage valid/ready issue pipeline for the combinational
//               64-bit ALU. Stage E registers operands and ALU Op; stage W
//               captures Result, branch decision and illegal flag.
//               Macro ALU_ISSUE_NOR_EN enables the R-type NOR encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_issue
    import alu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_aluop,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7b5,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_use_imm,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_taken,
    output logic            out_illegal
);

    logic [3:0] dec_op;
    logic       dec_is_branch;
    logic [1:0] dec_br_kind;
    logic       dec_illegal;

    alu_op_decode u_decode (
        .aluop_i     (in_aluop),
        .funct3_i    (in_funct3),
        .funct7b5_i  (in_funct7b5),
        .op_o        (dec_op),
        .is_branch_o (dec_is_branch),
        .br_kind_o   (dec_br_kind),
        .illegal_o   (dec_illegal)
    );

    // Stage E state
    logic            e_vld_q,       e_vld_d;
    logic [XLEN-1:0] alu_a_q,       alu_a_d;
    logic [XLEN-1:0] alu_b_q,       alu_b_d;
    logic [3:0]      alu_op_q,      alu_op_d;
    logic            e_is_branch_q, e_is_branch_d;
    logic [1:0]      e_br_kind_q,   e_br_kind_d;
    logic            e_illegal_q,   e_illegal_d;

    // Stage W state
    logic            out_valid_q,   out_valid_d;
    logic [XLEN-1:0] out_result_q,  out_result_d;
    logic            out_taken_q,   out_taken_d;
    logic            out_illegal_q, out_illegal_d;

    logic w_adv;
    logic e_adv;

    // A stage may move when it is empty or the stage after it is moving
    assign w_adv    = !out_valid_q || out_ready;
    assign e_adv    = !e_vld_q || w_adv;
    assign in_ready = e_adv;

    // E next state: load operands on accept, otherwise hold for the stalled ALU
    always_comb begin
        e_vld_d       = e_vld_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_op_d      = alu_op_q;
        e_is_branch_d = e_is_branch_q;
        e_br_kind_d   = e_br_kind_q;
        e_illegal_d   = e_illegal_q;
        if (e_adv) begin
            e_vld_d = in_valid;
            if (in_valid) begin
                alu_a_d       = in_rs1;
                alu_b_d       = in_use_imm ? in_imm : in_rs2;
                alu_op_d      = dec_op;
                e_is_branch_d = dec_is_branch;
                e_br_kind_d   = dec_br_kind;
                e_illegal_d   = dec_illegal;
            end
        end
    end

    // W next state: capture the ALU outputs when E hands its op over
    always_comb begin
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_taken_d   = out_taken_q;
        out_illegal_d = out_illegal_q;
        if (w_adv) begin
            out_valid_d = e_vld_q;
            if (e_vld_q) begin
                out_result_d  = alu_result;
                out_taken_d   = e_is_branch_q && !e_illegal_q
                                && branch_taken(e_br_kind_q, alu_zero);
                out_illegal_d = e_illegal_q;
            end
        end
    end

    // Pipeline registers; reset drops anything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_vld_q       <= 1'b0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= ALU_OP_ADD;
            e_is_branch_q <= 1'b0;
            e_br_kind_q   <= BR_EQ;
            e_illegal_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_taken_q   <= 1'b0;
            out_illegal_q <= 1'b0;
        end else begin
            e_vld_q       <= e_vld_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            e_is_branch_q <= e_is_branch_d;
            e_br_kind_q   <= e_br_kind_d;
            e_illegal_q   <= e_illegal_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_taken_q   <= out_taken_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_taken   = out_taken_q;
    assign out_illegal = out_illegal_q;

endmodule

`default_nettype wire
